instruction_fetch_unit: RTL

- Initiator side of the instruction-memory read interface.
- Holds the PC and drives the byte address to Instruction_memory, which has a 1-cycle registered read and big-endian byte order.
- Captures each returned 32-bit word and presents it to decode with a valid/ready handshake.
- Supports branch/jump redirect and flags illegal fetch addresses.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_addr_check.sv | 15 +
 rtl/instruction_fetch_unit.sv | 112 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch path: FSM encoding and address stepping.
package fetch_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam logic [31:0] PC_STEP    = 32'd4;

    typedef enum logic [1:0] {
        FS_ISSUE = 2'd0,
        FS_WAIT  = 2'd1,
        FS_HOLD  = 2'd2,
        FS_FAULT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_addr_check.sv
// Combinational legality check for a word access: aligned and inside the memory.
module fetch_addr_check
    import fetch_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic [31:0] addr,
    output logic        legal
);

    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - WORD_BYTES);

    assign legal = (addr[1:0] == 2'b00) && (addr <= LAST_WORD);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch initiator: drives pc to a 1-cycle registered memory and hands
// each returned word to decode through a valid/ready handshake.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   FS_ISSUE | pc presented to memory, legality decided
//   FS_WAIT  | memory data for pc on instruction_in, captured at the edge
//   FS_HOLD  | instruction held for decode, next pc already being read
//   FS_FAULT | fetch halted on an illegal pc, waits for redirect or reset
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] read_address,
    input  logic [31:0] instruction_in,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        decode_ready,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        fault,
    output logic [31:0] fetch_count
);

    fetch_state_t state;
    fetch_state_t state_nxt;
    logic [31:0]  pc;
    logic         pc_legal;
    logic         capture;
    logic         accept;

    fetch_addr_check #(
        .MEM_BYTES (MEM_BYTES)
    ) u_addr_check (
        .addr  (pc),
        .legal (pc_legal)
    );

    assign read_address = pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FS_ISSUE;
        end else begin
            state <= state_nxt;
        end
    end

    // Redirect overrides everything, including a pending accept.
    always_comb begin
        state_nxt = state;
        if (redirect) begin
            state_nxt = FS_ISSUE;
        end else begin
            case (state)
                FS_ISSUE: state_nxt = pc_legal ? FS_WAIT : FS_FAULT;
                FS_WAIT:  state_nxt = FS_HOLD;
                FS_HOLD: begin
                    if (decode_ready) begin
                        state_nxt = pc_legal ? FS_WAIT : FS_FAULT;
                    end
                end
                FS_FAULT: state_nxt = FS_FAULT;
                default:  state_nxt = FS_ISSUE;
            endcase
        end
    end

    always_comb begin
        instr_valid = 1'b0;
        fault       = 1'b0;
        capture     = 1'b0;
        accept      = 1'b0;
        case (state)
            FS_WAIT:  capture     = !redirect;
            FS_HOLD: begin
                instr_valid = 1'b1;
                accept      = decode_ready && !redirect;
            end
            FS_FAULT: fault       = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            instr_out   <= 32'd0;
            pc_out      <= 32'd0;
            fetch_count <= 32'd0;
        end else begin
            if (redirect) begin
                pc <= redirect_target;
            end else if (capture) begin
                pc <= pc + PC_STEP;
            end
            if (capture) begin
                instr_out <= instruction_in;
                pc_out    <= pc;
            end
            if (accept) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule
